// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. It decodes the instruction and resolves rs/rt operands through
// EX/MEM and MEM/WB forwarding, then registers the ALU operation, operands and control bits.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [15:0] imm,
    input  logic [4:0]  shamt_in,
    input  logic        exmem_wr_en,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_wr_en,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic        out_valid,
    output logic [3:0]  aluCnt,
    output logic [31:0] input1,
    output logic [31:0] input2,
    output logic [4:0]  shamt,
    output logic [4:0]  dest_reg,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        is_branch,
    output logic [31:0] store_data,
    output logic        illegal,
    output logic [15:0] bubble_count
);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_NOT = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0101;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    logic        w_legal;
    logic [3:0]  w_alu;
    logic [4:0]  w_dest;
    logic        w_reg_write;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_branch;
    logic        w_op2_rt;
    logic        w_sign_ext;
    logic        w_shift;
    logic [31:0] w_fwd_rs;
    logic [31:0] w_fwd_rt;
    logic [31:0] w_imm_ext;
    logic [31:0] w_op2;
    logic [4:0]  w_shamt;
    logic        w_bubble;
    logic [15:0] w_bubble_next;

    // Instruction decode
    always_comb begin
        w_legal     = 1'b1;
        w_alu       = ALU_ADD;
        w_dest      = rt_addr;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        w_op2_rt    = 1'b0;
        w_sign_ext  = 1'b1;
        w_shift     = 1'b0;
        case (opcode)
            6'b000000: begin
                w_dest      = rd_addr;
                w_reg_write = 1'b1;
                w_op2_rt    = 1'b1;
                case (funct)
                    6'b100000: w_alu = ALU_ADD;
                    6'b100010: w_alu = ALU_SUB;
                    6'b100111: w_alu = ALU_NOT;
                    6'b000000: begin
                        w_alu   = ALU_SLL;
                        w_shift = 1'b1;
                    end
                    6'b000010: begin
                        w_alu   = ALU_SRL;
                        w_shift = 1'b1;
                    end
                    6'b100100: w_alu = ALU_AND;
                    6'b100101: w_alu = ALU_OR;
                    6'b101010: w_alu = ALU_SLT;
                    default:   w_legal = 1'b0;
                endcase
            end
            6'b001000: begin
                w_alu       = ALU_ADD;
                w_reg_write = 1'b1;
            end
            6'b001010: begin
                w_alu       = ALU_SLT;
                w_reg_write = 1'b1;
            end
            6'b001100: begin
                w_alu       = ALU_AND;
                w_sign_ext  = 1'b0;
                w_reg_write = 1'b1;
            end
            6'b001101: begin
                w_alu       = ALU_OR;
                w_sign_ext  = 1'b0;
                w_reg_write = 1'b1;
            end
            6'b100011: begin
                w_alu       = ALU_ADD;
                w_mem_read  = 1'b1;
                w_reg_write = 1'b1;
            end
            6'b101011: begin
                w_alu       = ALU_ADD;
                w_mem_write = 1'b1;
            end
            6'b000100: begin
                w_alu    = ALU_SUB;
                w_branch = 1'b1;
                w_op2_rt = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Forwarding: the younger EX/MEM result wins over MEM/WB; register 0 never forwards
    always_comb begin
        w_fwd_rs = rs_data;
        if (exmem_wr_en && (exmem_rd != 5'd0) && (exmem_rd == rs_addr))
            w_fwd_rs = exmem_result;
        else if (memwb_wr_en && (memwb_rd != 5'd0) && (memwb_rd == rs_addr))
            w_fwd_rs = memwb_result;
    end

    always_comb begin
        w_fwd_rt = rt_data;
        if (exmem_wr_en && (exmem_rd != 5'd0) && (exmem_rd == rt_addr))
            w_fwd_rt = exmem_result;
        else if (memwb_wr_en && (memwb_rd != 5'd0) && (memwb_rd == rt_addr))
            w_fwd_rt = memwb_result;
    end

    assign w_imm_ext = w_sign_ext ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    assign w_op2     = w_op2_rt ? w_fwd_rt : w_imm_ext;
    assign w_shamt   = w_shift ? shamt_in : 5'd0;

    // Edges that load out_valid as 0 count as bubbles; stall edges do not
    assign w_bubble      = flush || (!stall && (!in_valid || !w_legal));
    assign w_bubble_next = (bubble_count == 16'hFFFF) ? bubble_count : bubble_count + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            aluCnt       <= 4'b0000;
            input1       <= 32'd0;
            input2       <= 32'd0;
            shamt        <= 5'd0;
            dest_reg     <= 5'd0;
            reg_write    <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            is_branch    <= 1'b0;
            store_data   <= 32'd0;
            illegal      <= 1'b0;
            bubble_count <= 16'd0;
        end else if (flush) begin
            out_valid    <= 1'b0;
            reg_write    <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            is_branch    <= 1'b0;
            illegal      <= 1'b0;
            bubble_count <= w_bubble_next;
        end else if (!stall) begin
            if (in_valid && w_legal) begin
                out_valid  <= 1'b1;
                aluCnt     <= w_alu;
                input1     <= w_fwd_rs;
                input2     <= w_op2;
                shamt      <= w_shamt;
                dest_reg   <= w_dest;
                reg_write  <= w_reg_write;
                mem_read   <= w_mem_read;
                mem_write  <= w_mem_write;
                is_branch  <= w_branch;
                store_data <= w_fwd_rt;
                illegal    <= 1'b0;
            end else begin
                // Bubble or illegal: datapath fields keep their last values
                out_valid  <= 1'b0;
                reg_write  <= 1'b0;
                mem_read   <= 1'b0;
                mem_write  <= 1'b0;
                is_branch  <= 1'b0;
                illegal    <= in_valid;
            end
            if (w_bubble)
                bubble_count <= w_bubble_next;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by randomized traffic,
// all compared against a behavioural model of the stage.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, stall, flush;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm;
    logic [4:0]  shamt_in;
    logic        exmem_wr_en, memwb_wr_en;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        out_valid, reg_write, mem_read, mem_write, is_branch, illegal;
    logic [3:0]  aluCnt;
    logic [31:0] input1, input2, store_data;
    logic [4:0]  shamt, dest_reg;
    logic [15:0] bubble_count;

    int n_checks = 0;
    int n_err    = 0;

    // Expected state of the stage
    logic        e_valid, e_rw, e_mr, e_mw, e_br, e_ill;
    logic [3:0]  e_alu;
    logic [31:0] e_in1, e_in2, e_sd;
    logic [4:0]  e_shamt, e_dest;
    int          e_bub;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .opcode(opcode), .funct(funct), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rd_addr(rd_addr), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .shamt_in(shamt_in), .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result), .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd),
        .memwb_result(memwb_result), .out_valid(out_valid), .aluCnt(aluCnt),
        .input1(input1), .input2(input2), .shamt(shamt), .dest_reg(dest_reg),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .is_branch(is_branch), .store_data(store_data), .illegal(illegal),
        .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input string fld, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s.%s observed %h expected %h", tag, fld, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check(tag, "out_valid", 32'(out_valid), 32'(e_valid));
        check(tag, "aluCnt", 32'(aluCnt), 32'(e_alu));
        check(tag, "input1", input1, e_in1);
        check(tag, "input2", input2, e_in2);
        check(tag, "shamt", 32'(shamt), 32'(e_shamt));
        check(tag, "dest_reg", 32'(dest_reg), 32'(e_dest));
        check(tag, "reg_write", 32'(reg_write), 32'(e_rw));
        check(tag, "mem_read", 32'(mem_read), 32'(e_mr));
        check(tag, "mem_write", 32'(mem_write), 32'(e_mw));
        check(tag, "is_branch", 32'(is_branch), 32'(e_br));
        check(tag, "store_data", store_data, e_sd);
        check(tag, "illegal", 32'(illegal), 32'(e_ill));
        check(tag, "bubble_count", 32'(bubble_count), 32'(e_bub));
    endtask

    task automatic model_reset();
        {e_valid, e_rw, e_mr, e_mw, e_br, e_ill} = '0;
        e_alu = '0; e_in1 = '0; e_in2 = '0; e_sd = '0; e_shamt = '0; e_dest = '0;
        e_bub = 0;
    endtask

    function automatic logic [31:0] fwd_ref(input logic [4:0] a, input logic [31:0] rf);
        if (exmem_wr_en && exmem_rd != 0 && exmem_rd == a) return exmem_result;
        if (memwb_wr_en && memwb_rd != 0 && memwb_rd == a) return memwb_result;
        return rf;
    endfunction

    task automatic bubble(input logic ill);
        {e_valid, e_rw, e_mr, e_mw, e_br} = '0;
        e_ill = ill;
        if (e_bub < 65535) e_bub++;
    endtask

    // Expected effect of the coming rising edge, computed from the current inputs
    task automatic model_edge();
        int  alu;
        bit  ok, rtype, sext, wr, rd_, wm, br;
        logic [31:0] ext;
        ok = 1; rtype = 0; sext = 1; wr = 0; rd_ = 0; wm = 0; br = 0; alu = 0;
        if (opcode == 0) begin
            rtype = 1; wr = 1;
            if      (funct == 6'd32) alu = 0;
            else if (funct == 6'd34) alu = 1;
            else if (funct == 6'd39) alu = 2;
            else if (funct == 6'd0)  alu = 3;
            else if (funct == 6'd2)  alu = 4;
            else if (funct == 6'd36) alu = 5;
            else if (funct == 6'd37) alu = 6;
            else if (funct == 6'd42) alu = 7;
            else ok = 0;
        end
        else if (opcode == 6'd8)  begin alu = 0; wr = 1; end
        else if (opcode == 6'd10) begin alu = 7; wr = 1; end
        else if (opcode == 6'd12) begin alu = 5; wr = 1; sext = 0; end
        else if (opcode == 6'd13) begin alu = 6; wr = 1; sext = 0; end
        else if (opcode == 6'd35) begin alu = 0; wr = 1; rd_ = 1; end
        else if (opcode == 6'd43) begin alu = 0; wm = 1; end
        else if (opcode == 6'd4)  begin alu = 1; br = 1; end
        else ok = 0;

        if (flush) begin
            bubble(1'b0);
            e_ill = 0;
        end else if (stall) begin
        end else if (!in_valid) begin
            bubble(1'b0);
        end else if (!ok) begin
            bubble(1'b1);
        end else begin
            ext = sext ? 32'($signed(imm)) : 32'(imm);
            e_valid = 1; e_alu = 4'(alu);
            e_in1 = fwd_ref(rs_addr, rs_data);
            e_sd  = fwd_ref(rt_addr, rt_data);
            e_in2 = (rtype || br) ? e_sd : ext;
            e_shamt = (rtype && (funct == 0 || funct == 2)) ? shamt_in : 5'd0;
            e_dest = rtype ? rd_addr : rt_addr;
            e_rw = wr; e_mr = rd_; e_mw = wm; e_br = br; e_ill = 0;
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                             input logic [4:0] rt, input logic [4:0] rd,
                             input logic [31:0] rsd, input logic [31:0] rtd,
                             input logic [15:0] im, input logic [4:0] sh);
        in_valid = 1; stall = 0; flush = 0;
        opcode = op; funct = fn; rs_addr = rs; rt_addr = rt; rd_addr = rd;
        rs_data = rsd; rt_data = rtd; imm = im; shamt_in = sh;
        exmem_wr_en = 0; exmem_rd = 0; exmem_result = 32'hDEAD0001;
        memwb_wr_en = 0; memwb_rd = 0; memwb_result = 32'hDEAD0002;
    endtask

    task automatic randomize_inputs();
        logic [5:0] ops [9];
        logic [5:0] fns [9];
        ops = '{6'd0, 6'd0, 6'd8, 6'd10, 6'd12, 6'd13, 6'd35, 6'd43, 6'd4};
        fns = '{6'd32, 6'd34, 6'd39, 6'd0, 6'd2, 6'd36, 6'd37, 6'd42, 6'd5};
        opcode = ($urandom_range(0, 15) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
        funct  = fns[$urandom_range(0, 8)];
        rs_addr = 5'($urandom_range(0, 7)); rt_addr = 5'($urandom_range(0, 7));
        rd_addr = 5'($urandom); rs_data = $urandom; rt_data = $urandom;
        imm = 16'($urandom); shamt_in = 5'($urandom);
        exmem_wr_en = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7));
        exmem_result = $urandom;
        memwb_wr_en = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7));
        memwb_result = $urandom;
        in_valid = ($urandom_range(0, 7) != 0);
        stall = ($urandom_range(0, 7) == 0);
        flush = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        rst = 1;
        set_instr(6'd0, 6'd32, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 5'd0);
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 0;

        set_instr(6'd0, 6'd32, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h1234, 5'd9);
        step("add");
        check("add", "in1_const", input1, 32'd5);
        check("add", "in2_const", input2, 32'd7);
        check("add", "dest_const", 32'(dest_reg), 32'd3);

        set_instr(6'd8, 6'd0, 5'd4, 5'd6, 5'd0, 32'd10, 32'd3, 16'hFFFE, 5'd0);
        step("addi");
        check("addi", "in2_const", input2, 32'hFFFFFFFE);
        set_instr(6'd13, 6'd0, 5'd4, 5'd6, 5'd0, 32'd10, 32'd3, 16'hFFFE, 5'd0);
        step("ori");
        check("ori", "in2_const", input2, 32'h0000FFFE);
        check("ori", "alu_const", 32'(aluCnt), 32'd6);

        set_instr(6'd0, 6'd34, 5'd8, 5'd8, 5'd9, 32'd1, 32'd2, 16'd0, 5'd0);
        exmem_wr_en = 1; exmem_rd = 8; exmem_result = 32'd100;
        memwb_wr_en = 1; memwb_rd = 8; memwb_result = 32'd200;
        step("sub_fwd");
        check("sub_fwd", "in1_const", input1, 32'd100);
        check("sub_fwd", "in2_const", input2, 32'd100);
        set_instr(6'd0, 6'd34, 5'd0, 5'd0, 5'd9, 32'd1, 32'd2, 16'd0, 5'd0);
        exmem_wr_en = 1; exmem_rd = 0; exmem_result = 32'd100;
        memwb_wr_en = 1; memwb_rd = 0; memwb_result = 32'd200;
        step("sub_r0");
        check("sub_r0", "in1_const", input1, 32'd1);
        set_instr(6'd0, 6'd34, 5'd8, 5'd3, 5'd9, 32'd1, 32'd2, 16'd0, 5'd0);
        memwb_wr_en = 1; memwb_rd = 8; memwb_result = 32'd200;
        step("sub_memwb");

        set_instr(6'd0, 6'd0, 5'd1, 5'd2, 5'd5, 32'd11, 32'd22, 16'd0, 5'd4);
        step("sll");
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            stall = 1; flush = 0;
            step("sll_stall");
            check("sll_stall", "shamt_const", 32'(shamt), 32'd4);
            check("sll_stall", "alu_const", 32'(aluCnt), 32'd3);
        end

        set_instr(6'd35, 6'd0, 5'd1, 5'd2, 5'd0, 32'd40, 32'd0, 16'd4, 5'd0);
        stall = 1; flush = 1;
        step("lw_stall_flush");
        set_instr(6'd35, 6'd0, 5'd1, 5'd2, 5'd0, 32'd40, 32'd0, 16'd4, 5'd0);
        step("lw");
        set_instr(6'h3F, 6'd0, 5'd1, 5'd2, 5'd0, 32'd40, 32'd0, 16'd4, 5'd0);
        step("illegal");
        check("illegal", "ill_const", 32'(illegal), 32'd1);
        randomize_inputs();
        stall = 1; flush = 0;
        step("illegal_stall");
        set_instr(6'd43, 6'd0, 5'd1, 5'd2, 5'd0, 32'd40, 32'd77, 16'h8000, 5'd0);
        step("sw");
        set_instr(6'd4, 6'd0, 5'd1, 5'd2, 5'd0, 32'd40, 32'd77, 16'h8000, 5'd0);
        step("beq");
        in_valid = 0;
        step("idle");

        set_instr(6'd0, 6'd37, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'd0, 5'd0);
        step("pre_rst");
        #2 rst = 1;
        model_reset();
        #1 check_all("async_rst");
        stall = 1; flush = 1;
        @(negedge clk);
        rst = 0;
        set_instr(6'd10, 6'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0003, 5'd0);
        step("post_rst");

        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1 clock (rising edge); rst in 1 reset, asynchronous, active-high.
REQ-002 SHALL have inputs: in_valid 1 decoded instruction present; stall 1 hold stage; flush 1 squash stage; opcode 6; funct 6; rs_addr/rt_addr/rd_addr 5 each; rs_data/rt_data 32 each, register-file read data; imm 16; shamt_in 5.
REQ-003 SHALL have forwarding inputs: exmem_wr_en 1; exmem_rd 5; exmem_result 32; memwb_wr_en 1; memwb_rd 5; memwb_result 32.
REQ-004 SHALL have registered outputs: out_valid 1; aluCnt 4; input1 32; input2 32; shamt 5; dest_reg 5; reg_write 1; mem_read 1; mem_write 1; is_branch 1; store_data 32; illegal 1; bubble_count 16.

Function
REQ-005 SHALL decode R-type (opcode 000000) funct to aluCnt: 100000 add 0000; 100010 sub 0001; 100111 not 0010; 000000 sll 0011; 000010 srl 0100; 100100 and 0101; 100101 or 0110; 101010 slt 0111; dest rd; reg_write 1.
REQ-006 SHALL decode I-type: addi 001000 add, sign-ext imm; slti 001010 slt, sign-ext; andi 001100 and, zero-ext; ori 001101 or, zero-ext; all dest rt, reg_write 1.
REQ-007 SHALL decode lw 100011 (add, sign-ext, mem_read 1, dest rt, reg_write 1), sw 101011 (add, sign-ext, mem_write 1, reg_write 0), beq 000100 (sub, input2 = forwarded rt, is_branch 1, reg_write 0).
REQ-008 Any other opcode/funct with in_valid 1 SHALL load illegal 1, out_valid 0, all control outputs 0.
REQ-009 Forwarded operand per source (rs, rt): exmem_result if exmem_wr_en, exmem_rd != 0, exmem_rd == addr; else memwb_result under same rule with memwb_*; else rs_data/rt_data. EX/MEM SHALL win when both match.
REQ-010 input1 SHALL be forwarded rs; input2 SHALL be forwarded rt for R-type and beq, extended imm otherwise; store_data SHALL be forwarded rt.
REQ-011 shamt SHALL be shamt_in for sll/srl, 0 otherwise.
REQ-012 Latency SHALL be one cycle: values decoded from inputs at edge N appear on outputs after edge N.
REQ-013 Edge priority SHALL be flush > stall > load.
REQ-014 flush SHALL clear out_valid, reg_write, mem_read, mem_write, is_branch, illegal; datapath outputs hold.
REQ-015 stall (no flush) SHALL hold every output unchanged, including illegal.
REQ-016 Load with in_valid 0 SHALL clear out_valid and all control outputs, illegal 0; datapath outputs hold.
REQ-017 bubble_count SHALL increment by 1 on each edge where out_valid is loaded 0 (flush, load with in_valid 0, illegal), not on stall; SHALL saturate at 16'hFFFF.
REQ-018 Stage SHALL be purely forwarding: no load-use detection; stall is supplied externally.

Reset
REQ-019 rst high SHALL immediately set every output to 0 (aluCnt 0000, bubble_count 0) independent of clk.
REQ-020 Reset asserted mid-stall or mid-flush SHALL dominate; first edge after deassertion SHALL perform a normal load.

Verification
REQ-021 add rs=1 rt=2 rd=3, rs_data 5, rt_data 7, no forwarding -> next cycle aluCnt 0000, input1 5, input2 7, dest_reg 3, reg_write 1, out_valid 1.
REQ-022 addi rs=4 imm 16'hFFFE, rs_data 10 -> input2 32'hFFFFFFFE, aluCnt 0000; ori same imm -> input2 32'h0000FFFE, aluCnt 0110.
REQ-023 sub rs=rt=8; exmem_wr_en 1 exmem_rd 8 exmem_result 100; memwb_wr_en 1 memwb_rd 8 memwb_result 200 -> input1 100, input2 100; repeat with rd 0 on both -> register data used.
REQ-024 sll shamt_in 4 loaded, then stall 3 cycles with changing inputs -> outputs hold aluCnt 0011, shamt 4; bubble_count unchanged.
REQ-025 stall and flush together on valid lw -> out_valid 0, mem_read 0, bubble_count +1; opcode 111111 -> illegal 1, out_valid 0.
REQ-026 rst pulsed between edges while out_valid 1 -> all outputs 0 before next edge.
